// File: rtl/gcd_sched.sv
// gcd_sched: round-robin front end that shares one GCD engine between
// N requesters, with zero bypass, run timeout and tagged responses.
module gcd_sched #(
    parameter int N       = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [N*DW-1:0]      req_u,
    input  logic [N*DW-1:0]      req_v,
    output logic [N-1:0]         req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [DW-1:0]        rsp_res,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 eng_ld,
    output logic [DW-1:0]        eng_u,
    output logic [DW-1:0]        eng_v,
    input  logic [DW-1:0]        eng_res,
    input  logic                 eng_done
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] job_id;
    logic [IW-1:0] gnt_id;
    logic [IW-1:0] idx;
    logic [IW-1:0] nxt_ptr;
    logic          gnt_found;
    logic [DW-1:0] sel_u;
    logic [DW-1:0] sel_v;
    logic [7:0]    timer;
    logic          timeout;

    // First valid requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((32'(rr_ptr) + 32'(k)) % 32'(N));
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    always_comb begin
        sel_u = '0;
        sel_v = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_id == IW'(k)) begin
                sel_u = req_u[k*DW +: DW];
                sel_v = req_v[k*DW +: DW];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign nxt_ptr = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
    assign timeout = (timer == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            job_id    <= '0;
            timer     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_res   <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            eng_ld    <= 1'b0;
            eng_u     <= '0;
            eng_v     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_found) begin
                        job_id <= gnt_id;
                        eng_u  <= sel_u;
                        eng_v  <= sel_v;
                        rr_ptr <= nxt_ptr;
                        busy   <= 1'b1;
                        // gcd(0,x) = x needs no engine pass
                        if (sel_u == '0 || sel_v == '0) begin
                            rsp_id    <= gnt_id;
                            rsp_res   <= sel_u | sel_v;
                            rsp_err   <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            eng_ld <= 1'b1;
                            state  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    eng_ld <= 1'b0;
                    timer  <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    timer <= timer + 8'd1;
                    if (eng_done) begin
                        rsp_id    <= job_id;
                        rsp_res   <= eng_res;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (timeout) begin
                        rsp_id    <= job_id;
                        rsp_res   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched: two instances (default timeout and
// TIMEOUT=4), each driving a subtractive GCD engine model.
module tb_gcd_sched;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;

    logic [3:0]  req_valid = '0;
    logic [31:0] req_u     = '0;
    logic [31:0] req_v     = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_res;
    logic        rsp_err;
    logic        busy;
    logic        eng_ld;
    logic [7:0]  eng_u;
    logic [7:0]  eng_v;
    logic [7:0]  eng_res;
    logic        eng_done;

    logic [3:0]  req_valid_b = '0;
    logic [31:0] req_u_b     = '0;
    logic [31:0] req_v_b     = '0;
    logic [3:0]  req_ready_b;
    logic        rsp_valid_b;
    logic        rsp_ready_b = 1'b0;
    logic [1:0]  rsp_id_b;
    logic [7:0]  rsp_res_b;
    logic        rsp_err_b;
    logic        busy_b;
    logic        eng_ld_b;
    logic [7:0]  eng_u_b;
    logic [7:0]  eng_v_b;
    logic [7:0]  eng_res_b;
    logic        eng_done_b;

    logic [7:0]  ea_u = '0;
    logic [7:0]  ea_v = '0;
    logic [7:0]  eb_u = '0;
    logic [7:0]  eb_v = '0;

    int checks = 0;
    int errors = 0;
    int ld_cnt = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    gcd_sched #(.N(4), .DW(8), .TIMEOUT(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_u(req_u), .req_v(req_v),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_err(rsp_err),
        .busy(busy), .eng_ld(eng_ld), .eng_u(eng_u), .eng_v(eng_v),
        .eng_res(eng_res), .eng_done(eng_done)
    );

    gcd_sched #(.N(4), .DW(8), .TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_u(req_u_b), .req_v(req_v_b),
        .req_ready(req_ready_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_id(rsp_id_b), .rsp_res(rsp_res_b), .rsp_err(rsp_err_b),
        .busy(busy_b), .eng_ld(eng_ld_b), .eng_u(eng_u_b),
        .eng_v(eng_v_b),
        .eng_res(eng_res_b), .eng_done(eng_done_b)
    );

    // Subtractive GCD engines: one step per cycle, done when u == v.
    always @(posedge clk) begin
        if (eng_ld) begin
            ea_u <= eng_u;
            ea_v <= eng_v;
        end else if (ea_u > ea_v) ea_u <= ea_u - ea_v;
        else if (ea_v > ea_u) ea_v <= ea_v - ea_u;
    end
    assign eng_res  = ea_u;
    assign eng_done = (ea_u == ea_v);

    always @(posedge clk) begin
        if (eng_ld_b) begin
            eb_u <= eng_u_b;
            eb_v <= eng_v_b;
        end else if (eb_u > eb_v) eb_u <= eb_u - eb_v;
        else if (eb_v > eb_u) eb_v <= eb_v - eb_u;
    end
    assign eng_res_b  = eb_u;
    assign eng_done_b = (eb_u == eb_v);

    always @(negedge clk) begin
        if (eng_ld) ld_cnt++;
        if (rsp_valid && rsp_ready) hs_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one job on port p of dut; return one step after transfer.
    task automatic do_xfer(input int p, input logic [7:0] u,
                           input logic [7:0] v);
        int n;
        req_valid[p]      = 1'b1;
        req_u[p*8 +: 8]   = u;
        req_v[p*8 +: 8]   = v;
        #1;
        n = 0;
        while (!req_ready[p] && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        chk("xfer_grant", 32'(req_ready), 32'(1) << p);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
    endtask

    // Cycles from transfer (cycle 0) until rsp_valid is seen.
    task automatic wait_rsp(input bit b, output int n);
        n = 1;
        while (!(b ? rsp_valid_b : rsp_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int l0;
        int h0;
        int eu[4];
        int ev[4];
        int er[4];
        int en[4];
        eu = '{12, 9, 7, 100};
        ev = '{8, 6, 7, 75};
        er = '{4, 3, 7, 25};
        en = '{5, 5, 3, 6};

        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_id}), 0);
        chk("rst_res", 32'(rsp_res), 0);
        chk("rst_eng", 32'({eng_ld, eng_u, eng_v}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_b", 32'({busy_b, rsp_valid_b, req_ready_b}), 0);
        repeat (2) @(posedge clk);
        #1;
        reset       = 1'b0;
        rsp_ready   = 1'b1;
        rsp_ready_b = 1'b1;

        // Basic engine job
        l0 = ld_cnt;
        do_xfer(0, 8'd48, 8'd18);
        chk("t1_ld", 32'(eng_ld), 1);
        chk("t1_eng", 32'({eng_u, eng_v}), {16'd0, 8'd48, 8'd18});
        chk("t1_busy", 32'(busy), 1);
        wait_rsp(1'b0, n);
        chk("t1_lat", n, 7);
        chk("t1_res", 32'(rsp_res), 6);
        chk("t1_id", 32'(rsp_id), 0);
        chk("t1_err", 32'(rsp_err), 0);
        @(posedge clk); #1;
        chk("t1_idle", 32'({busy, rsp_valid}), 0);
        chk("t1_ldcnt", ld_cnt - l0, 1);

        // Zero-operand bypass
        l0 = ld_cnt;
        do_xfer(2, 8'd0, 8'd35);
        wait_rsp(1'b0, n);
        chk("t2_lat", n, 1);
        chk("t2_res", 32'(rsp_res), 35);
        chk("t2_id", 32'(rsp_id), 2);
        @(posedge clk); #1;
        do_xfer(2, 8'd0, 8'd0);
        wait_rsp(1'b0, n);
        chk("t2_lat0", n, 1);
        chk("t2_res0", 32'(rsp_res), 0);
        @(posedge clk); #1;
        do_xfer(3, 8'd5, 8'd0);
        wait_rsp(1'b0, n);
        chk("t2_res5", 32'(rsp_res), 5);
        chk("t2_id3", 32'(rsp_id), 3);
        chk("t2_noload", ld_cnt - l0, 0);
        @(posedge clk); #1;

        // All four requesters valid together
        req_u     = {8'd100, 8'd7, 8'd9, 8'd12};
        req_v     = {8'd75, 8'd7, 8'd6, 8'd8};
        req_valid = 4'hF;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("t3_gnt", 32'(req_ready), 32'(1) << j);
            @(posedge clk); #1;
            req_valid[j] = 1'b0;
            wait_rsp(1'b0, n);
            chk("t3_lat", n, en[j]);
            chk("t3_res", 32'(rsp_res), er[j]);
            chk("t3_id", 32'(rsp_id), j);
            @(posedge clk); #1;
        end
        req_valid = 4'b0101;
        #1;
        chk("t3_rearm", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        wait_rsp(1'b0, n);
        chk("t3_res0", 32'(rsp_res), 4);
        chk("t3_id0", 32'(rsp_id), 0);
        @(posedge clk); #1;
        chk("t3_drop", 32'({busy, req_ready}), 0);

        // Timeout on the TIMEOUT=4 instance, then done-wins case
        req_u_b[7:0] = 8'd255;
        req_v_b[7:0] = 8'd1;
        req_valid_b  = 4'b0001;
        #1;
        chk("t4_gnt", 32'(req_ready_b), 1);
        @(posedge clk); #1;
        req_valid_b = '0;
        wait_rsp(1'b1, n);
        chk("t4_lat", n, 6);
        chk("t4_err", 32'(rsp_err_b), 1);
        chk("t4_res", 32'(rsp_res_b), 0);
        @(posedge clk); #1;
        req_u_b[7:0] = 8'd10;
        req_v_b[7:0] = 8'd4;
        req_valid_b  = 4'b0001;
        #1;
        @(posedge clk); #1;
        req_valid_b = '0;
        wait_rsp(1'b1, n);
        chk("t4_lat2", n, 6);
        chk("t4_res2", 32'(rsp_res_b), 2);
        chk("t4_err2", 32'(rsp_err_b), 0);
        @(posedge clk); #1;
        chk("t4_idle", 32'({busy_b, rsp_valid_b}), 0);

        // Backpressure on the response channel
        rsp_ready = 1'b0;
        do_xfer(1, 8'd21, 8'd14);
        wait_rsp(1'b0, n);
        chk("t5_lat", n, 5);
        req_valid = 4'b1101;
        h0 = hs_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("t5_valid", 32'(rsp_valid), 1);
            chk("t5_res", 32'(rsp_res), 7);
            chk("t5_id", 32'(rsp_id), 1);
            chk("t5_ready", 32'(req_ready), 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        chk("t5_drop", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        chk("t5_hs", hs_cnt - h0, 1);
        chk("t5_idle", 32'(busy), 0);

        // Reset in the middle of a RUN
        do_xfer(2, 8'd200, 8'd150);
        @(posedge clk); #1;
        chk("t6_run", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("t6_ready", 32'(req_ready), 0);
        chk("t6_flags",
            32'({rsp_valid, rsp_err, rsp_id, busy, eng_ld}), 0);
        chk("t6_res", 32'(rsp_res), 0);
        chk("t6_eng", 32'({eng_u, eng_v}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        h0 = hs_cnt;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_norsp", 32'({rsp_valid, busy}), 0);
        chk("t6_nohs", hs_cnt - h0, 0);
        do_xfer(0, 8'd200, 8'd150);
        wait_rsp(1'b0, n);
        chk("t6_lat", n, 6);
        chk("t6_res2", 32'(rsp_res), 50);
        chk("t6_id2", 32'(rsp_id), 0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
